ff_bank: RTL and testbench

Parametrised bank of WIDTH independent single-bit storage channels sharing one clock. A run-time mode selects SR, JK, D or T behaviour for all channels. SR illegal inputs (S=R=1) are resolved by a parameterised policy and logged in per-channel sticky error flags and a saturating event counter. The bank is the general-purpose successor to the single SR flip-flop, used wherever a group of control bits needs set/reset/toggle semantics with error visibility.

---
 rtl/ff_bank.sv | 102 ++++++++++
 tb/tb_ff_bank.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ff_bank.sv
// Bank of WIDTH single-bit storage channels with run-time SR/JK/D/T behaviour,
// sticky per-channel SR-illegal flags and a saturating illegal-cycle counter.
module ff_bank #(
  parameter int                 WIDTH          = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL      = '0,
  parameter int                 ILLEGAL_POLICY = 0,
  parameter int                 CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mode_t            mode_sel;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] err_reg, err_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_base;
  logic [WIDTH-1:0] illegal_vec;

  assign mode_sel    = mode_t'(mode);
  assign illegal_vec = (en && mode_sel == MODE_SR) ? (s & r) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      always_comb begin
        q_next[gi] = q_reg[gi];
        if (en) begin
          unique case (mode_sel)
            MODE_SR: begin
              case ({s[gi], r[gi]})
                2'b10: q_next[gi] = 1'b1;
                2'b01: q_next[gi] = 1'b0;
                2'b11: begin
                  if (ILLEGAL_POLICY == 1)      q_next[gi] = 1'b1;
                  else if (ILLEGAL_POLICY == 2) q_next[gi] = 1'b0;
                  else                          q_next[gi] = q_reg[gi];
                end
                default: q_next[gi] = q_reg[gi];
              endcase
            end
            MODE_JK: begin
              case ({s[gi], r[gi]})
                2'b10:   q_next[gi] = 1'b1;
                2'b01:   q_next[gi] = 1'b0;
                2'b11:   q_next[gi] = ~q_reg[gi];
                default: q_next[gi] = q_reg[gi];
              endcase
            end
            MODE_D:  q_next[gi] = s[gi];
            MODE_T:  q_next[gi] = s[gi] ? ~q_reg[gi] : q_reg[gi];
            default: q_next[gi] = q_reg[gi];
          endcase
        end
      end
    end
  endgenerate

  // A same-cycle illegal event survives clr_err: clearing happens first, then logging.
  always_comb begin
    err_next = (clr_err ? '0 : err_reg) | illegal_vec;
    cnt_base = clr_err ? '0 : cnt_reg;
    cnt_next = cnt_base;
    if (|illegal_vec && cnt_base != CNT_MAX)
      cnt_next = cnt_base + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg   <= RESET_VAL;
      err_reg <= '0;
      cnt_reg <= '0;
    end else begin
      q_reg   <= q_next;
      err_reg <= err_next;
      cnt_reg <= cnt_next;
    end
  end

  assign q       = q_reg;
  assign qbar    = ~q_reg;
  assign err     = err_reg;
  assign err_cnt = cnt_reg;

endmodule

// File: tb/tb_ff_bank.sv
// Directed bench for ff_bank: three instances share stimulus and differ in
// illegal-input policy (0/1/2); the policy-2 instance also has a 2-bit counter.
module tb_ff_bank;

  localparam logic [1:0] M_SR = 2'b00, M_JK = 2'b01, M_D = 2'b10, M_T = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n, en, clr_err;
  logic [1:0] mode;
  logic [3:0] s, r;

  logic [3:0] q0, qbar0, err0, q1, qbar1, err1, q2, qbar2, err2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ff_bank #(.WIDTH(4), .RESET_VAL(4'b1010), .ILLEGAL_POLICY(0), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .r(r), .clr_err(clr_err),
    .q(q0), .qbar(qbar0), .err(err0), .err_cnt(cnt0));

  ff_bank #(.WIDTH(4), .RESET_VAL(4'b1010), .ILLEGAL_POLICY(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .r(r), .clr_err(clr_err),
    .q(q1), .qbar(qbar1), .err(err1), .err_cnt(cnt1));

  ff_bank #(.WIDTH(4), .RESET_VAL(4'b1010), .ILLEGAL_POLICY(2), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .r(r), .clr_err(clr_err),
    .q(q2), .qbar(qbar2), .err(err2), .err_cnt(cnt2));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = M_T; s = 4'hF; r = 4'h0; clr_err = 1'b0;
    #1;
    step(); step();
    check_val("rst_q",    {28'd0, q0},    32'hA);
    check_val("rst_qbar", {28'd0, qbar0}, 32'h5);
    check_val("rst_err",  {28'd0, err0},  32'h0);
    check_val("rst_cnt",  {24'd0, cnt0},  32'h0);

    rst_n = 1'b1;
    step();
    check_val("rel_toggle_q",    {28'd0, q0},    32'h5);
    check_val("rel_toggle_qbar", {28'd0, qbar0}, 32'hA);

    mode = M_D; s = 4'h0;
    step();
    check_val("d_zero_q", {28'd0, q0}, 32'h0);

    // SR: ch0 illegal, ch1 set, ch2 reset, ch3 hold
    mode = M_SR; s = 4'b0011; r = 4'b0101;
    step();
    check_val("sr_p0_q",   {28'd0, q0},   32'h2);
    check_val("sr_p1_q",   {28'd0, q1},   32'h3);
    check_val("sr_p2_q",   {28'd0, q2},   32'h2);
    check_val("sr_p0_err", {28'd0, err0}, 32'h1);
    check_val("sr_p0_cnt", {24'd0, cnt0}, 32'h1);
    check_val("sr_p2_cnt", {30'd0, cnt2}, 32'h1);

    mode = M_D; s = 4'h0; r = 4'h0; clr_err = 1'b1;
    step();
    check_val("clr_err",   {28'd0, err0}, 32'h0);
    check_val("clr_cnt",   {24'd0, cnt0}, 32'h0);
    check_val("clr_d_q",   {28'd0, q0},   32'h0);
    clr_err = 1'b0;

    mode = M_JK; s = 4'hF; r = 4'hF;
    step(); check_val("jk_t1", {28'd0, q0}, 32'hF);
    step(); check_val("jk_t2", {28'd0, q0}, 32'h0);
    step(); check_val("jk_t3", {28'd0, q0}, 32'hF);
    check_val("jk_err", {28'd0, err0}, 32'h0);

    mode = M_T; s = 4'b0101; r = 4'h0;
    step(); check_val("t_1", {28'd0, q0}, 32'hA);
    step(); check_val("t_2", {28'd0, q0}, 32'hF);
    check_val("t_err", {28'd0, err0}, 32'h0);

    mode = M_D; s = 4'b0110;
    step(); check_val("d_load", {28'd0, q0}, 32'h6);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s = 4'(4'h9 + i);
      step();
      check_val($sformatf("en0_hold%0d", i), {28'd0, q0}, 32'h6);
    end
    en = 1'b1; s = 4'b1100;
    step(); check_val("d_en1", {28'd0, q0}, 32'hC);

    // Saturation: 2-bit counter in u_dut2 stops at 3, 8-bit one keeps counting
    mode = M_SR; s = 4'b0001; r = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val($sformatf("sat_cnt%0d", i), {30'd0, cnt2}, (i < 3) ? i + 1 : 3);
    end
    check_val("cnt8_5", {24'd0, cnt0}, 32'd5);

    en = 1'b0;
    step();
    check_val("en0_cnt_hold", {24'd0, cnt0}, 32'd5);
    check_val("en0_err_hold", {28'd0, err0}, 32'h1);
    en = 1'b1;

    clr_err = 1'b1; s = 4'b0010; r = 4'b0010;
    step();
    check_val("coll_err", {28'd0, err0}, 32'h2);
    check_val("coll_cnt", {24'd0, cnt0}, 32'h1);

    mode = M_D; s = 4'h0; r = 4'h0;
    step();
    check_val("clr2_err", {28'd0, err0}, 32'h0);
    check_val("clr2_cnt", {24'd0, cnt0}, 32'h0);
    clr_err = 1'b0;

    // Reset while saturated must override fully
    mode = M_SR; s = 4'hF; r = 4'hF;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    check_val("midrst_q",   {28'd0, q2},   32'hA);
    check_val("midrst_err", {28'd0, err2}, 32'h0);
    check_val("midrst_cnt", {30'd0, cnt2}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
